graphics_rect_draw: RTL and testbench
=====================================

Name: graphics_rect_draw

Overview:
Parametrised successor to the fixed-width rectangle filler in the graphics engine. It takes two corner points, a colour and a mode (solid fill or 1-pixel outline) over an Avalon-MM CSR port. It clips the rectangle to the screen, then streams the affected pixels in raster order over an Avalon-ST source into the frame-buffer writer. Start/done/clken control matches the other graphics operation blocks.

Parameters:
COORD_WIDTH, 10, bits per x/y coordinate (unsigned)
COLOR_WIDTH, 8, bits per pixel colour
SCREEN_WIDTH, 640, visible columns; x clipped to SCREEN_WIDTH-1
SCREEN_HEIGHT, 480, visible rows; y clipped to SCREEN_HEIGHT-1
CSR_ADDR_WIDTH, 2, CSR address bits
CSR_DATA_WIDTH, 32, CSR data bits; must be >= 2*COORD_WIDTH and >= COLOR_WIDTH

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
mm_csr_write  in  1  CSR write strobe
mm_csr_address  in  CSR_ADDR_WIDTH  0=POINT1, 1=POINT2, 2=COLOR, 3=MODE
mm_csr_writedata  in  CSR_DATA_WIDTH  points {y[2C-1:C], x[C-1:0]}; COLOR in [COLOR_WIDTH-1:0]; MODE bit0 (0=fill, 1=outline)
mm_csr_waitrequest  out  1  high while state != IDLE
clken  in  1  global enable; all state/datapath updates gated by it
start  in  1  begin operation (sampled in IDLE only)
done  out  1  one-cycle pulse on completion
st_ready  in  1  sink ready
st_data  out  COLOR_WIDTH+2*COORD_WIDTH  {color, y, x}, x in LSBs
st_valid  out  1  pixel valid

Behaviour:
- Reset (async, reset==0): state=IDLE; POINT1/POINT2/COLOR/MODE=0; st_valid=0, done=0, mm_csr_waitrequest=0, st_data=0.
- CSR: a write in IDLE with clken don't-care updates the addressed register next edge. Writes while waitrequest=1 are stalled per Avalon: the master holds the write and no register changes.
- FSM (advances only when clken=1): IDLE -start-> SETUP -> DRAW or DONE; DRAW -last pixel accepted-> DONE; DONE -> IDLE. start outside IDLE is ignored.
- SETUP (1 cycle):
  - xmin/xmax = min/max of point x; ymin/ymax likewise.
  - If xmin > SCREEN_WIDTH-1 or ymin > SCREEN_HEIGHT-1: empty rectangle, go straight to DONE with no beats.
  - Otherwise xmax=min(xmax, SCREEN_WIDTH-1) and ymax=min(ymax, SCREEN_HEIGHT-1).
  - Cursor=(xmin, ymin); colour and mode latched. Later CSR writes do not affect the running operation.
- DRAW:
  - st_valid = clken && state==DRAW. The beat is accepted when st_valid && st_ready. On acceptance the cursor advances; otherwise st_data is held stable.
  - Fill: x increments to xmax, then x=xmin, y+1.
  - Outline: rows ymin and ymax emit every x in [xmin, xmax]. Interior rows emit only xmin and xmax, so the cursor jumps xmin->xmax. If xmin==xmax, each row emits one pixel. If ymin==ymax, the single row is emitted once.
  - Last pixel = (xmax, ymax). Its acceptance moves to DONE.
  - No pixel is emitted twice; order is strictly raster.
- Outline is drawn on the clipped rectangle, so clipped sides appear at the screen edge.
- done = (state==DONE), high for exactly one clken-qualified cycle.
- Latency: start edge -> first st_valid = 2 clken cycles. Fill pixel count = (xmax-xmin+1)*(ymax-ymin+1) after clipping.
- Coordinate arithmetic in COORD_WIDTH bits. No wrap is possible because the cursor never exceeds the clipped max.
- clken=0 mid-DRAW: st_valid drops, the cursor freezes, and the operation resumes unchanged.
- Reset mid-operation: immediate abort to IDLE, st_valid=0, no done pulse.

Optional Feature:
GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN
- Defined: adds output pixel_count (2*COORD_WIDTH bits). It is cleared to 0 on the SETUP cycle, increments on each accepted beat, and holds after DONE until the next start. Reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Fill P1=(5,3), P2=(2,1), colour 0x2A, ready=1 -> 12 beats (2..5)x(1..3) in raster order, all colour 0x2A, then one done pulse; first valid 2 cycles after start.
- Outline P1=(0,0), P2=(3,2) -> beats (0,0)(1,0)(2,0)(3,0)(0,1)(3,1)(0,2)(1,2)(2,2)(3,2): 10 beats, then done.
- Clip: fill P1=(638,478), P2=(700,900) -> 4 beats (638..639)x(478..479). Separately, P1=(650,10), P2=(700,20) -> 0 beats, done 2 cycles after start.
- Backpressure: fill 2x2, st_ready toggled 1,0,0,1,... and clken low for 3 cycles mid-run -> st_data stable while stalled, exactly 4 accepted beats, no duplicates. start pulsed during DRAW is ignored. CSR write during DRAW sees waitrequest=1.
- Degenerate outline P1=P2=(7,9) -> single beat (7,9). Outline (4,1)-(4,3) -> beats (4,1)(4,2)(4,3).
- Reset asserted after 3 of 12 beats -> st_valid=0 immediately, registers=0, no done. With GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN, pixel_count=12 after the first scenario and 0 after reset.

Source files
------------

// File: rtl/graphics_rect_draw.sv
// Clipped rectangle drawer: CSR-loaded corners/colour/mode, raster pixel stream out.
// Optional pixel counter output enabled by GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN.
`timescale 1ns/1ps
module graphics_rect_draw #(
  parameter int COORD_WIDTH    = 10,
  parameter int COLOR_WIDTH    = 8,
  parameter int SCREEN_WIDTH   = 640,
  parameter int SCREEN_HEIGHT  = 480,
  parameter int CSR_ADDR_WIDTH = 2,
  parameter int CSR_DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 mm_csr_write,
  input  logic [CSR_ADDR_WIDTH-1:0]            mm_csr_address,
  input  logic [CSR_DATA_WIDTH-1:0]            mm_csr_writedata,
  output logic                                 mm_csr_waitrequest,
  input  logic                                 clken,
  input  logic                                 start,
  output logic                                 done,
  input  logic                                 st_ready,
  output logic [COLOR_WIDTH+2*COORD_WIDTH-1:0] st_data,
  output logic                                 st_valid,
`ifdef GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN
  output logic [2*COORD_WIDTH-1:0]             pixel_count,
`endif
  output logic [1:0]                           dbg_state
);

  localparam logic [COORD_WIDTH-1:0] X_LIM = COORD_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LIM = COORD_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] ONE_C = COORD_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2*COORD_WIDTH-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [COLOR_WIDTH-1:0]   color_q, color_d, lat_color_q, lat_color_d;
  logic                     mode_q, mode_d, lat_mode_q, lat_mode_d;
  logic [COORD_WIDTH-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_WIDTH-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic [COORD_WIDTH-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;

  logic [COORD_WIDTH-1:0] p1x, p1y, p2x, p2y;
  logic [COORD_WIDTH-1:0] sx_lo, sx_hi, sy_lo, sy_hi;
  logic                   rect_empty;
  logic                   accept, last_px, edge_row;
  logic                   unused_wdata;

  assign unused_wdata = ^mm_csr_writedata;

  // Corner sorting and clipping, consumed only in the SETUP cycle
  always_comb begin
    p1x   = p1_q[COORD_WIDTH-1:0];
    p1y   = p1_q[2*COORD_WIDTH-1:COORD_WIDTH];
    p2x   = p2_q[COORD_WIDTH-1:0];
    p2y   = p2_q[2*COORD_WIDTH-1:COORD_WIDTH];
    sx_lo = (p1x < p2x) ? p1x : p2x;
    sx_hi = (p1x < p2x) ? p2x : p1x;
    sy_lo = (p1y < p2y) ? p1y : p2y;
    sy_hi = (p1y < p2y) ? p2y : p1y;
    rect_empty = (sx_lo > X_LIM) || (sy_lo > Y_LIM);
  end

  assign accept   = st_valid && st_ready;
  assign last_px  = (cur_x_q == xmax_q) && (cur_y_q == ymax_q);
  assign edge_row = (cur_y_q == ymin_q) || (cur_y_q == ymax_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clken) begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_SETUP;
        S_SETUP: state_d = rect_empty ? S_DONE : S_DRAW;
        S_DRAW:  if (accept && last_px) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    st_valid           = clken && (state_q == S_DRAW);
    done               = clken && (state_q == S_DONE);
    mm_csr_waitrequest = (state_q != S_IDLE);
    st_data            = {lat_color_q, cur_y_q, cur_x_q};
    dbg_state          = state_q;
  end

  // CSR registers accept writes only while idle; otherwise the master is stalled
  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    color_d = color_q;
    mode_d  = mode_q;
    if (mm_csr_write && (state_q == S_IDLE)) begin
      case (mm_csr_address)
        2'd0:    p1_d    = mm_csr_writedata[2*COORD_WIDTH-1:0];
        2'd1:    p2_d    = mm_csr_writedata[2*COORD_WIDTH-1:0];
        2'd2:    color_d = mm_csr_writedata[COLOR_WIDTH-1:0];
        default: mode_d  = mm_csr_writedata[0];
      endcase
    end
  end

  // Operation bounds and cursor
  always_comb begin
    lat_color_d = lat_color_q;
    lat_mode_d  = lat_mode_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    if (clken && (state_q == S_SETUP)) begin
      lat_color_d = color_q;
      lat_mode_d  = mode_q;
      xmin_d      = sx_lo;
      ymin_d      = sy_lo;
      xmax_d      = (sx_hi > X_LIM) ? X_LIM : sx_hi;
      ymax_d      = (sy_hi > Y_LIM) ? Y_LIM : sy_hi;
      cur_x_d     = sx_lo;
      cur_y_d     = sy_lo;
    end else if (accept && !last_px) begin
      if (cur_x_q == xmax_q) begin
        cur_x_d = xmin_q;
        cur_y_d = cur_y_q + ONE_C;
      end else if (lat_mode_q && !edge_row) begin
        // Interior outline rows only touch the two side columns
        cur_x_d = xmax_q;
      end else begin
        cur_x_d = cur_x_q + ONE_C;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_q        <= '0;
      p2_q        <= '0;
      color_q     <= '0;
      mode_q      <= 1'b0;
      lat_color_q <= '0;
      lat_mode_q  <= 1'b0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
    end else begin
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      color_q     <= color_d;
      mode_q      <= mode_d;
      lat_color_q <= lat_color_d;
      lat_mode_q  <= lat_mode_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
    end
  end

`ifdef GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN
  logic [2*COORD_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clken && (state_q == S_SETUP)) cnt_d = '0;
    else if (accept)                   cnt_d = cnt_q + (2*COORD_WIDTH)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pixel_count = cnt_q;
`endif

endmodule

// File: tb/tb_graphics_rect_draw.sv
// Bench for graphics_rect_draw: reference rectangle model feeds an expected-pixel
// queue that a negedge monitor compares against every accepted beat.
`timescale 1ns/1ps
module tb_graphics_rect_draw;

  localparam int C  = 10;
  localparam int K  = 8;
  localparam int W  = K + 2*C;
  localparam int SW = 640;
  localparam int SH = 480;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          mm_csr_write = 1'b0;
  logic [1:0]    mm_csr_address = 2'd0;
  logic [31:0]   mm_csr_writedata = 32'd0;
  logic          mm_csr_waitrequest;
  logic          clken = 1'b1;
  logic          start = 1'b0;
  logic          done;
  logic          st_ready = 1'b1;
  logic [W-1:0]  st_data;
  logic          st_valid;
  logic [1:0]    dbg_state;
`ifdef GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN
  logic [2*C-1:0] pixel_count;
`endif

  graphics_rect_draw dut (
    .clk                (clk),
    .reset              (reset),
    .mm_csr_write       (mm_csr_write),
    .mm_csr_address     (mm_csr_address),
    .mm_csr_writedata   (mm_csr_writedata),
    .mm_csr_waitrequest (mm_csr_waitrequest),
    .clken              (clken),
    .start              (start),
    .done               (done),
    .st_ready           (st_ready),
    .st_data            (st_data),
    .st_valid           (st_valid),
`ifdef GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN
    .pixel_count        (pixel_count),
`endif
    .dbg_state          (dbg_state)
  );

  // Scoreboard
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] beat_log [0:63];
  int           op_beats = 0;
  int           dones = 0;
  logic         stall_pend = 1'b0;
  logic [W-1:0] stall_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: every pixel of the clipped rectangle (or its border) in raster order
  task automatic model_push(input int x1, input int y1, input int x2, input int y2,
                            input logic [K-1:0] col, input logic outline);
    int xl, xh, yl, yh;
    logic [C-1:0] xv, yv;
    xl = (x1 < x2) ? x1 : x2;
    xh = (x1 < x2) ? x2 : x1;
    yl = (y1 < y2) ? y1 : y2;
    yh = (y1 < y2) ? y2 : y1;
    if (xl > SW-1 || yl > SH-1) return;
    if (xh > SW-1) xh = SW-1;
    if (yh > SH-1) yh = SH-1;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (!outline || y == yl || y == yh || x == xl || x == xh) begin
          xv = x[C-1:0];
          yv = y[C-1:0];
          exp_q.push_back({col, yv, xv});
        end
      end
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (reset) begin
      if (!clken) check("valid_gated", {31'd0, st_valid}, 32'd0);
      if (st_valid) begin
        if (stall_pend) check("stall_hold", {4'd0, st_data}, {4'd0, stall_data});
        if (st_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got %0h expected no beat", st_data);
          end else begin
            check("beat", {4'd0, st_data}, {4'd0, exp_q.pop_front()});
          end
          if (op_beats < 64) beat_log[op_beats] = st_data;
          op_beats++;
          stall_pend = 1'b0;
        end else begin
          stall_pend = 1'b1;
          stall_data = st_data;
        end
      end
      if (done) begin
        check("done_q_empty", exp_q.size(), 32'd0);
        dones++;
      end
    end
  end

  // Driver tasks (called at posedge+1)
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    mm_csr_write     = 1'b1;
    mm_csr_address   = a;
    mm_csr_writedata = d;
    @(posedge clk); #1;
    mm_csr_write     = 1'b0;
  endtask

  function automatic logic [31:0] pt(input int x, input int y);
    logic [31:0] d;
    d = 32'd0;
    d[C-1:0]   = x[C-1:0];
    d[2*C-1:C] = y[C-1:0];
    return d;
  endfunction

  task automatic load(input int x1, input int y1, input int x2, input int y2,
                      input logic [K-1:0] col, input logic outline, input logic wr_col);
    csr_wr(2'd0, pt(x1, y1));
    csr_wr(2'd1, pt(x2, y2));
    if (wr_col) csr_wr(2'd2, {24'd0, col});
    csr_wr(2'd3, {31'd0, outline});
    model_push(x1, y1, x2, y2, col, outline);
  endtask

  task automatic run_op(input int x1, input int y1, input int x2, input int y2,
                        input logic [K-1:0] col, input logic outline, input logic wr_col,
                        input string nm);
    int exp_n, d0, cyc;
    load(x1, y1, x2, y2, col, outline, wr_col);
    exp_n    = exp_q.size();
    op_beats = 0;
    d0       = dones;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({nm, "_setup_valid"}, {31'd0, st_valid}, 32'd0);
    check({nm, "_setup_waitreq"}, {31'd0, mm_csr_waitrequest}, 32'd1);
    @(negedge clk);
    if (exp_n > 0) check({nm, "_latency_valid"}, {31'd0, st_valid}, 32'd1);
    else           check({nm, "_latency_done"}, {31'd0, done}, 32'd1);
    cyc = 0;
    while (dones == d0 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (cyc >= 2000) check({nm, "_timeout"}, 32'd1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_beats"}, op_beats, exp_n);
    check({nm, "_done_once"}, dones - d0, 32'd1);
    check({nm, "_idle_waitreq"}, {31'd0, mm_csr_waitrequest}, 32'd0);
  endtask

  logic [3:0] rdy_pat;

  initial begin
    int d0, cyc;
    rdy_pat = 4'b1001;
    #2 reset = 1'b0;
    #1;
    check("rst_valid", {31'd0, st_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_waitreq", {31'd0, mm_csr_waitrequest}, 32'd0);
    check("rst_data", {4'd0, st_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Fill, swapped corners
    run_op(5, 3, 2, 1, 8'h2A, 1'b0, 1'b1, "fill");
    check("fill_count", op_beats, 32'd12);
    check("fill_first", {4'd0, beat_log[0]}, {4'd0, 8'h2A, 10'd1, 10'd2});
    check("fill_5th", {4'd0, beat_log[4]}, {4'd0, 8'h2A, 10'd2, 10'd2});
    check("fill_last", {4'd0, beat_log[11]}, {4'd0, 8'h2A, 10'd3, 10'd5});
`ifdef GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN
    check("fill_pixel_count", {12'd0, pixel_count}, 32'd12);
`endif

    // Outline
    run_op(0, 0, 3, 2, 8'h55, 1'b1, 1'b1, "outline");
    check("outline_count", op_beats, 32'd10);
    check("outline_b4", {4'd0, beat_log[4]}, {4'd0, 8'h55, 10'd1, 10'd0});
    check("outline_b5", {4'd0, beat_log[5]}, {4'd0, 8'h55, 10'd1, 10'd3});
    check("outline_b9", {4'd0, beat_log[9]}, {4'd0, 8'h55, 10'd2, 10'd3});

    // Clipping
    run_op(638, 478, 700, 900, 8'h0C, 1'b0, 1'b1, "clip");
    check("clip_count", op_beats, 32'd4);
    check("clip_first", {4'd0, beat_log[0]}, {4'd0, 8'h0C, 10'd478, 10'd638});
    check("clip_last", {4'd0, beat_log[3]}, {4'd0, 8'h0C, 10'd479, 10'd639});
    run_op(650, 10, 700, 20, 8'h0D, 1'b0, 1'b1, "offscreen");
    check("offscreen_count", op_beats, 32'd0);
    run_op(630, 470, 900, 900, 8'h0E, 1'b1, 1'b1, "clip_outline");

    // Backpressure, clken gap, ignored start, stalled CSR write
    load(10, 20, 11, 21, 8'h11, 1'b0, 1'b1);
    op_beats = 0;
    d0 = dones;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60 && dones == d0; i++) begin
      st_ready = rdy_pat[i % 4];
      clken    = !(i >= 3 && i <= 5);
      start    = (i == 6);
      if (i == 2) begin
        mm_csr_write     = 1'b1;
        mm_csr_address   = 2'd2;
        mm_csr_writedata = 32'hFF;
      end
      @(negedge clk);
      if (i == 2) check("bp_waitreq", {31'd0, mm_csr_waitrequest}, 32'd1);
      @(posedge clk); #1;
    end
    start    = 1'b0;
    st_ready = 1'b1;
    clken    = 1'b1;
    if (dones == d0) check("bp_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    mm_csr_write = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_count", op_beats, 32'd4);
    check("bp_done_once", dones - d0, 32'd1);
    check("bp_idle_valid", {31'd0, st_valid}, 32'd0);

    // Colour written by the stalled write lands once idle
    run_op(5, 5, 5, 5, 8'hFF, 1'b0, 1'b0, "held_wr");
    check("held_wr_beat", {4'd0, beat_log[0]}, {4'd0, 8'hFF, 10'd5, 10'd5});

    // Degenerate outlines
    run_op(7, 9, 7, 9, 8'h21, 1'b1, 1'b1, "dot");
    check("dot_count", op_beats, 32'd1);
    check("dot_beat", {4'd0, beat_log[0]}, {4'd0, 8'h21, 10'd9, 10'd7});
    run_op(4, 1, 4, 3, 8'h22, 1'b1, 1'b1, "vline");
    check("vline_count", op_beats, 32'd3);
    check("vline_mid", {4'd0, beat_log[1]}, {4'd0, 8'h22, 10'd2, 10'd4});
    run_op(2, 6, 9, 6, 8'h23, 1'b1, 1'b1, "hline");
    check("hline_count", op_beats, 32'd8);

    // Reset mid-operation
    load(5, 3, 2, 1, 8'h2A, 1'b0, 1'b1);
    op_beats = 0;
    d0 = dones;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (op_beats < 3 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 50) check("rst_mid_timeout", 32'd1, 32'd0);
    #1;
`ifdef GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN
    check("mid_pixel_count", {12'd0, pixel_count}, 32'd3);
`endif
    #1 reset = 1'b0;
    #1;
    exp_q.delete();
    stall_pend = 1'b0;
    check("rst_mid_valid", {31'd0, st_valid}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_waitreq", {31'd0, mm_csr_waitrequest}, 32'd0);
    check("rst_mid_data", {4'd0, st_data}, 32'd0);
`ifdef GRAPHICS_RECT_DRAW_PIXEL_COUNT_EN
    check("rst_pixel_count", {12'd0, pixel_count}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_done", dones - d0, 32'd0);
    check("rst_mid_beats", op_beats, 32'd3);
    check("rst_after_valid", {31'd0, st_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
